regfile_mp: RTL and testbench

- Parametrised multi-read-port register file; next generation of the team's fixed 16x16 two-read-port file.
- Adds configurable width, depth and read-port count, per-entry valid bits, optional write-first bypass, optional registered reads, an optional hardwired zero register and a sequenced bulk-clear engine with a busy/done handshake.
- Sits in the datapath as the architectural register store feeding ALU operand muxes.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_mp_if.sv | 34 +++
 rtl/regfile_clear_seq.sv | 72 +++++++
 rtl/regfile_mp.sv | 135 +++++++++++++
 tb/tb_regfile_mp.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared definitions for the multi-port register file:
//   - clr_state_e : states of the bulk-clear sequencer
//   - slice_lo()  : low bit of port 'port' on a flat bus of 'width'-bit fields
package regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_e;

  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if
//   Bus between a register-file user (master) and regfile_mp (slave).
//   Signals:
//     we / waddr / wdata       : write port
//     raddr                    : NUM_RD packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//     rdata / rvalid           : NUM_RD packed read results, port i at [i*DATA_W +: DATA_W]
//     clr_req                  : single-cycle bulk-clear request
//     clr_busy / clr_done      : clear in progress / one-cycle completion pulse
interface regfile_mp_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int NUM_RD = 2,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic                       we;
  logic [ADDR_W-1:0]          waddr;
  logic [DATA_W-1:0]          wdata;
  logic [NUM_RD*ADDR_W-1:0]   raddr;
  logic [NUM_RD*DATA_W-1:0]   rdata;
  logic [NUM_RD-1:0]          rvalid;
  logic                       clr_req;
  logic                       clr_busy;
  logic                       clr_done;

  modport master (
    output we, waddr, wdata, raddr, clr_req,
    input  rdata, rvalid, clr_busy, clr_done
  );

  modport slave (
    input  we, waddr, wdata, raddr, clr_req,
    output rdata, rvalid, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_clear_seq.sv
// regfile_clear_seq
//   Walks every entry of the register file once, clearing one entry per
//   cycle, then pulses clr_done.
//   Ports:
//     clk, reset        : clock, asynchronous active-high reset
//     clr_req           : start request (ignored unless idle)
//     clr_busy          : high for exactly DEPTH cycles while clearing
//     clr_done          : one-cycle pulse after the last entry is cleared
//     clr_we / clr_idx  : clear strobe and entry index for the storage array
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    clr_busy = 1'b0;
    clr_done = 1'b0;
    clr_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        if (idx_q == LAST) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        clr_done = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clr_idx = idx_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Parametrised multi-read-port register file with per-entry valid bits,
//   optional write-first bypass, optional registered reads, optional
//   hardwired zero register and a sequenced bulk-clear engine.
//   Ports:
//     clk, reset : clock, asynchronous active-high reset (clears everything)
//     bus        : regfile_mp_if slave (write port, NUM_RD read ports, clear handshake)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int RD_REG   = 0,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic        clk,
  input  logic        reset,
  regfile_mp_if.slave bus
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic              clr_busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_acc;

  regfile_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (bus.clr_req),
    .clr_busy (clr_busy),
    .clr_done (bus.clr_done),
    .clr_we   (clr_we),
    .clr_idx  (clr_idx)
  );

  assign bus.clr_busy = clr_busy;

  // A write lands only when no clear is running, the address exists and it
  // is not the hardwired zero entry. The bypass keys off the same signal so
  // a dropped write is never forwarded.
  always_comb begin
    wr_acc = bus.we && !clr_busy && (32'(bus.waddr) < 32'(DEPTH));
    if (ZERO_REG != 0 && bus.waddr == '0) begin
      wr_acc = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i]   = mem_q[i];
      valid_d[i] = valid_q[i];
    end
    if (clr_we) begin
      mem_d[clr_idx]   = '0;
      valid_d[clr_idx] = 1'b0;
    end else if (wr_acc) begin
      mem_d[bus.waddr]   = bus.wdata;
      valid_d[bus.waddr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      localparam int AL = slice_lo(gi, ADDR_W);
      localparam int DL = slice_lo(gi, DATA_W);

      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd_data_d;
      logic              rd_valid_d;

      assign ra = bus.raddr[AL +: ADDR_W];

      // Priority: zero register, then range check, then bypass, then array.
      always_comb begin
        rd_data_d  = '0;
        rd_valid_d = 1'b0;
        if (ZERO_REG != 0 && ra == '0) begin
          rd_valid_d = 1'b1;
        end else if (32'(ra) < 32'(DEPTH)) begin
          if (BYPASS != 0 && wr_acc && bus.waddr == ra) begin
            rd_data_d  = bus.wdata;
            rd_valid_d = 1'b1;
          end else begin
            rd_data_d  = mem_q[ra];
            rd_valid_d = valid_q[ra];
          end
        end
      end

      if (RD_REG != 0) begin : g_reg
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_valid_q;

        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
          end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
          end
        end

        assign bus.rdata[DL +: DATA_W] = rd_data_q;
        assign bus.rvalid[gi]          = rd_valid_q;
      end else begin : g_comb
        assign bus.rdata[DL +: DATA_W] = rd_data_d;
        assign bus.rvalid[gi]          = rd_valid_d;
      end
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
//   Self-checking bench for regfile_mp. Four instances cover the main
//   configurations:
//     u0 : defaults (combinational read, bypass on)
//     u1 : bypass off
//     u2 : registered read
//     u3 : zero register, 4 read ports, 12 entries
//   A simple array model of u0 tracks contents and valid bits.
module tb_regfile_mp;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  regfile_mp_if #(.DATA_W(16), .DEPTH(16), .NUM_RD(2)) b0 ();
  regfile_mp_if #(.DATA_W(16), .DEPTH(16), .NUM_RD(2)) b1 ();
  regfile_mp_if #(.DATA_W(16), .DEPTH(16), .NUM_RD(2)) b2 ();
  regfile_mp_if #(.DATA_W(16), .DEPTH(12), .NUM_RD(4)) b3 ();

  regfile_mp #(.DATA_W(16), .DEPTH(16), .NUM_RD(2), .RD_REG(0), .BYPASS(1), .ZERO_REG(0))
    u0 (.clk(clk), .reset(reset), .bus(b0));
  regfile_mp #(.DATA_W(16), .DEPTH(16), .NUM_RD(2), .RD_REG(0), .BYPASS(0), .ZERO_REG(0))
    u1 (.clk(clk), .reset(reset), .bus(b1));
  regfile_mp #(.DATA_W(16), .DEPTH(16), .NUM_RD(2), .RD_REG(1), .BYPASS(1), .ZERO_REG(0))
    u2 (.clk(clk), .reset(reset), .bus(b2));
  regfile_mp #(.DATA_W(16), .DEPTH(12), .NUM_RD(4), .RD_REG(0), .BYPASS(1), .ZERO_REG(1))
    u3 (.clk(clk), .reset(reset), .bus(b3));

  // Reference model of u0
  logic [15:0] m_mem [16];
  logic        m_val [16];

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 16'h0;
      m_val[i] = 1'b0;
    end
  endtask

  task automatic drive_idle();
    b0.we = 1'b0; b0.waddr = '0; b0.wdata = '0; b0.raddr = '0; b0.clr_req = 1'b0;
    b1.we = 1'b0; b1.waddr = '0; b1.wdata = '0; b1.raddr = '0; b1.clr_req = 1'b0;
    b2.we = 1'b0; b2.waddr = '0; b2.wdata = '0; b2.raddr = '0; b2.clr_req = 1'b0;
    b3.we = 1'b0; b3.waddr = '0; b3.wdata = '0; b3.raddr = '0; b3.clr_req = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (b2.rdata !== 32'h0 || b2.rvalid !== 2'b00) begin
      errors++;
      $display("FAIL reset_rdreg got %h/%b want 00000000/00", b2.rdata, b2.rvalid);
    end
    reset = 1'b0;
    m_reset();
    for (int a = 0; a < 16; a++) begin
      b0.raddr = {4'(a), 4'(a)};
      #1;
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (b0.rdata[p*16 +: 16] !== 16'h0 || b0.rvalid[p] !== 1'b0) begin
          errors++;
          $display("FAIL reset_read addr=%0d port=%0d got %h/%b want 0000/0",
                   a, p, b0.rdata[p*16 +: 16], b0.rvalid[p]);
        end
      end
    end
    checks++;
    if (b0.clr_busy !== 1'b0 || b0.clr_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_clr got busy=%b done=%b want 0/0", b0.clr_busy, b0.clr_done);
    end
  endtask

  task automatic test_write_read();
    tick();
    b0.we = 1'b1; b0.waddr = 4'd5; b0.wdata = 16'hBEEF; b0.raddr = '0;
    tick();
    b0.we = 1'b0;
    m_mem[5] = 16'hBEEF; m_val[5] = 1'b1;
    b0.raddr = {4'd0, 4'd5};
    #1;
    checks++;
    if (b0.rdata[15:0] !== 16'hBEEF || b0.rvalid[0] !== 1'b1) begin
      errors++;
      $display("FAIL write_read got %h/%b want beef/1", b0.rdata[15:0], b0.rvalid[0]);
    end
  endtask

  task automatic test_bypass();
    tick();
    b0.we = 1'b1; b0.waddr = 4'd3; b0.wdata = 16'h1234; b0.raddr = {4'd3, 4'd0};
    b1.we = 1'b1; b1.waddr = 4'd3; b1.wdata = 16'h1234; b1.raddr = {4'd3, 4'd0};
    #1;
    checks++;
    if (b0.rdata[31:16] !== 16'h1234 || b0.rvalid[1] !== 1'b1) begin
      errors++;
      $display("FAIL bypass_on got %h/%b want 1234/1", b0.rdata[31:16], b0.rvalid[1]);
    end
    checks++;
    if (b1.rdata[31:16] !== 16'h0 || b1.rvalid[1] !== 1'b0) begin
      errors++;
      $display("FAIL bypass_off got %h/%b want 0000/0", b1.rdata[31:16], b1.rvalid[1]);
    end
    tick();
    b0.we = 1'b0; b1.we = 1'b0;
    m_mem[3] = 16'h1234; m_val[3] = 1'b1;
    #1;
    checks++;
    if (b1.rdata[31:16] !== 16'h1234 || b1.rvalid[1] !== 1'b1) begin
      errors++;
      $display("FAIL bypass_off_after got %h/%b want 1234/1", b1.rdata[31:16], b1.rvalid[1]);
    end
  endtask

  task automatic test_rd_reg();
    tick();
    b2.we = 1'b1; b2.waddr = 4'd7; b2.wdata = 16'hA5A5; b2.raddr = {4'd0, 4'd7};
    #1;
    checks++;
    if (b2.rvalid[0] !== 1'b0) begin
      errors++;
      $display("FAIL rdreg_latency got rvalid=%b want 0", b2.rvalid[0]);
    end
    tick();
    b2.we = 1'b0;
    checks++;
    if (b2.rdata[15:0] !== 16'hA5A5 || b2.rvalid[0] !== 1'b1) begin
      errors++;
      $display("FAIL rdreg_first got %h/%b want a5a5/1", b2.rdata[15:0], b2.rvalid[0]);
    end
    b2.raddr = {4'd0, 4'd11};
    #1;
    checks++;
    if (b2.rdata[15:0] !== 16'hA5A5) begin
      errors++;
      $display("FAIL rdreg_hold got %h want a5a5", b2.rdata[15:0]);
    end
    tick();
    checks++;
    if (b2.rdata[15:0] !== 16'h0 || b2.rvalid[0] !== 1'b0) begin
      errors++;
      $display("FAIL rdreg_unwritten got %h/%b want 0000/0", b2.rdata[15:0], b2.rvalid[0]);
    end
  endtask

  task automatic test_zero_reg();
    logic [15:0] z_mem [12];
    logic [15:0] ed;
    z_mem[0] = 16'h0;
    for (int a = 1; a < 12; a++) begin
      tick();
      z_mem[a] = 16'($urandom);
      b3.we = 1'b1; b3.waddr = 4'(a); b3.wdata = z_mem[a];
    end
    tick();
    b3.we = 1'b1; b3.waddr = 4'd0; b3.wdata = 16'hFFFF; b3.raddr = '0;
    #1;
    checks++;
    if (b3.rdata[15:0] !== 16'h0 || b3.rvalid[0] !== 1'b1) begin
      errors++;
      $display("FAIL zero_nobypass got %h/%b want 0000/1", b3.rdata[15:0], b3.rvalid[0]);
    end
    tick();
    b3.we = 1'b1; b3.waddr = 4'd13; b3.wdata = 16'hFFFF; b3.raddr = {4'd0, 4'd0, 4'd13, 4'd0};
    #1;
    checks++;
    if (b3.rdata[31:16] !== 16'h0 || b3.rvalid[1] !== 1'b0) begin
      errors++;
      $display("FAIL zero_oor_bypass got %h/%b want 0000/0", b3.rdata[31:16], b3.rvalid[1]);
    end
    tick();
    b3.we = 1'b0;
    for (int a = 0; a < 14; a++) begin
      b3.raddr = {4'(a), 4'(a), 4'(a), 4'(a)};
      #1;
      ed = (a < 12) ? z_mem[a] : 16'h0;
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (b3.rdata[p*16 +: 16] !== ed || b3.rvalid[p] !== (a < 12)) begin
          errors++;
          $display("FAIL zero_read addr=%0d port=%0d got %h/%b want %h/%b",
                   a, p, b3.rdata[p*16 +: 16], b3.rvalid[p], ed, (a < 12));
        end
      end
    end
  endtask

  task automatic test_random();
    logic        we;
    logic [3:0]  wa, ra;
    logic [3:0]  r [2];
    logic [15:0] wd, ed;
    logic        ev;
    tick();
    for (int n = 0; n < 300; n++) begin
      we   = 1'($urandom_range(0, 1));
      wa   = 4'($urandom_range(0, 15));
      wd   = 16'($urandom);
      r[0] = 4'($urandom_range(0, 15));
      r[1] = ($urandom_range(0, 3) == 0) ? r[0] : 4'($urandom_range(0, 15));
      b0.we = we; b0.waddr = wa; b0.wdata = wd; b0.raddr = {r[1], r[0]};
      #1;
      for (int p = 0; p < 2; p++) begin
        ra = r[p];
        ed = m_mem[ra];
        ev = m_val[ra];
        if (we && wa == ra) begin
          ed = wd;
          ev = 1'b1;
        end
        checks++;
        if (b0.rdata[p*16 +: 16] !== ed || b0.rvalid[p] !== ev) begin
          errors++;
          $display("FAIL random n=%0d port=%0d addr=%0d got %h/%b want %h/%b",
                   n, p, ra, b0.rdata[p*16 +: 16], b0.rvalid[p], ed, ev);
        end
      end
      tick();
      if (we) begin
        m_mem[wa] = wd;
        m_val[wa] = 1'b1;
      end
    end
    b0.we = 1'b0;
  endtask

  task automatic test_clear();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at  = -1;
    for (int a = 0; a < 16; a++) begin
      b0.we = 1'b1; b0.waddr = 4'(a); b0.wdata = 16'($urandom);
      tick();
      m_mem[a] = b0.wdata; m_val[a] = 1'b1;
    end
    b0.we = 1'b0; b0.clr_req = 1'b1;
    tick();
    b0.clr_req = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (b0.clr_busy === 1'b1) busy_cnt++;
      if (b0.clr_done === 1'b1) begin
        done_cnt++;
        done_at = i;
      end
      b0.we = (i < 16); b0.waddr = 4'd2; b0.wdata = 16'hDEAD;
      b0.clr_req = (i == 3 || i == 16);
      if (i == 1) begin
        b0.raddr = {4'd2, 4'd15};
        #1;
        checks++;
        if (b0.rdata[15:0] !== m_mem[15] || b0.rvalid[0] !== 1'b1) begin
          errors++;
          $display("FAIL clear_uncleared got %h/%b want %h/1", b0.rdata[15:0], b0.rvalid[0], m_mem[15]);
        end
        checks++;
        if (b0.rdata[31:16] !== m_mem[2] || b0.rvalid[1] !== 1'b1) begin
          errors++;
          $display("FAIL clear_drop_nobypass got %h/%b want %h/1", b0.rdata[31:16], b0.rvalid[1], m_mem[2]);
        end
      end
      tick();
    end
    b0.we = 1'b0; b0.clr_req = 1'b0;
    checks++;
    if (busy_cnt != 16 || done_cnt != 1 || done_at != 16) begin
      errors++;
      $display("FAIL clear_timing got busy=%0d done=%0d at=%0d want 16/1/16", busy_cnt, done_cnt, done_at);
    end
    m_reset();
    for (int a = 0; a < 16; a++) begin
      b0.raddr = {4'(a), 4'(a)};
      #1;
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (b0.rdata[p*16 +: 16] !== 16'h0 || b0.rvalid[p] !== 1'b0) begin
          errors++;
          $display("FAIL clear_after addr=%0d port=%0d got %h/%b want 0000/0",
                   a, p, b0.rdata[p*16 +: 16], b0.rvalid[p]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy_cnt = 0;
    tick();
    b0.we = 1'b1; b0.waddr = 4'd9; b0.wdata = 16'h0F0F;
    tick();
    b0.we = 1'b0; b0.clr_req = 1'b1;
    tick();
    b0.clr_req = 1'b0;
    repeat (4) tick();
    checks++;
    if (b0.clr_busy !== 1'b1) begin
      errors++;
      $display("FAIL midclr_busy got %b want 1", b0.clr_busy);
    end
    reset = 1'b1;
    b0.raddr = {4'd9, 4'd9};
    #1;
    checks++;
    if (b0.clr_busy !== 1'b0 || b0.clr_done !== 1'b0 || b0.rdata[15:0] !== 16'h0 || b0.rvalid[0] !== 1'b0) begin
      errors++;
      $display("FAIL midclr_reset got busy=%b done=%b rd=%h/%b want 0/0 0000/0",
               b0.clr_busy, b0.clr_done, b0.rdata[15:0], b0.rvalid[0]);
    end
    tick();
    reset = 1'b0;
    m_reset();
    b0.we = 1'b1; b0.waddr = 4'd4; b0.wdata = 16'h1111; b0.clr_req = 1'b1;
    tick();
    b0.we = 1'b0; b0.clr_req = 1'b0; b0.raddr = {4'd0, 4'd4};
    for (int i = 0; i < 24; i++) begin
      if (b0.clr_busy === 1'b1) busy_cnt++;
      if (i == 0) begin
        #1;
        checks++;
        if (b0.rdata[15:0] !== 16'h1111 || b0.rvalid[0] !== 1'b1) begin
          errors++;
          $display("FAIL req_with_write got %h/%b want 1111/1", b0.rdata[15:0], b0.rvalid[0]);
        end
      end
      tick();
    end
    checks++;
    if (busy_cnt != 16) begin
      errors++;
      $display("FAIL post_reset_clear got busy=%0d want 16", busy_cnt);
    end
    checks++;
    if (b0.rdata[15:0] !== 16'h0 || b0.rvalid[0] !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_erased got %h/%b want 0000/0", b0.rdata[15:0], b0.rvalid[0]);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_rd_reg();
    test_zero_reg();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
